// File: rtl/pe_accum_float.sv
// Sequential single-precision accumulator for the PE multiplier output stream.
// One term per pass through ALIGN/ADD/NORM; no denormals, no NaN/Inf, truncation rounding.
module pe_accum_float #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    state_t             state;
    logic [31:0]        acc;
    logic [31:0]        b_reg;
    logic               last_reg;
    logic [CNT_W-1:0]   term_cnt;

    logic               byp;
    logic [31:0]        byp_val;
    logic               sx;
    logic [7:0]         ex;
    logic [23:0]        mx;
    logic [23:0]        my;
    logic               sub;
    logic [24:0]        sum;

    logic               a_zero;
    logic               b_zero;
    logic               a_ge;
    logic [31:0]        x_op;
    logic [31:0]        y_op;
    logic [7:0]         diff;
    logic [23:0]        my_full;
    logic [23:0]        my_sh;
    logic               al_byp;
    logic [31:0]        al_byp_val;

    logic [4:0]         lz;
    logic [22:0]        norm_mant;
    logic [8:0]         e_inc;
    logic [9:0]         e_dec;
    logic [31:0]        res;

    assign in_ready = (state == IDLE);

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Order accumulator and new term by magnitude; the smaller one is aligned to the larger.
    always_comb begin
        a_zero     = (acc[30:23] == 8'd0);
        b_zero     = (b_reg[30:23] == 8'd0);
        a_ge       = (acc[30:0] >= b_reg[30:0]);
        x_op       = a_ge ? acc : b_reg;
        y_op       = a_ge ? b_reg : acc;
        diff       = x_op[30:23] - y_op[30:23];
        my_full    = {1'b1, y_op[22:0]};
        my_sh      = (diff >= 8'd25) ? 24'd0 : (my_full >> diff);
        al_byp     = a_zero | b_zero;
        al_byp_val = b_zero ? acc : b_reg;
    end

    always_comb begin
        lz        = lzc24(sum[23:0]);
        norm_mant = 23'(sum[23:0] << lz);
        e_inc     = {1'b0, ex} + 9'd1;
        e_dec     = {2'b00, ex} - {5'b00000, lz};
        res       = 32'd0;
        if (byp) begin
            res = byp_val;
        end else if (sum[24]) begin
            if (e_inc >= 9'd255) begin
                res = {sx, 8'hFE, 23'h7FFFFF};
            end else begin
                res = {sx, e_inc[7:0], sum[23:1]};
            end
        end else if (sum == 25'd0) begin
            res = 32'd0;
        end else if (e_dec[9] || (e_dec == 10'd0)) begin
            res = 32'd0;
        end else begin
            res = {sx, e_dec[7:0], norm_mant};
        end
    end

    // Control FSM and datapath registers; clr outranks every state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 32'd0;
            b_reg     <= 32'd0;
            last_reg  <= 1'b0;
            term_cnt  <= '0;
            out_data  <= 32'd0;
            out_valid <= 1'b0;
            out_count <= '0;
            byp       <= 1'b0;
            byp_val   <= 32'd0;
            sx        <= 1'b0;
            ex        <= 8'd0;
            mx        <= 24'd0;
            my        <= 24'd0;
            sub       <= 1'b0;
            sum       <= 25'd0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= 32'd0;
            term_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_reg    <= in_data;
                        last_reg <= in_last;
                        term_cnt <= term_cnt + CNT_W'(1);
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    byp     <= al_byp;
                    byp_val <= al_byp_val;
                    sx      <= x_op[31];
                    ex      <= x_op[30:23];
                    mx      <= {1'b1, x_op[22:0]};
                    my      <= my_sh;
                    sub     <= x_op[31] ^ y_op[31];
                    state   <= ADD;
                end
                ADD: begin
                    if (sub) begin
                        sum <= {1'b0, mx} - {1'b0, my};
                    end else begin
                        sum <= {1'b0, mx} + {1'b0, my};
                    end
                    state <= NORM;
                end
                NORM: begin
                    acc <= res;
                    if (last_reg) begin
                        out_data  <= res;
                        out_count <= term_cnt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= 32'd0;
                        term_cnt  <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_accum_float.sv
// Self-checking bench for pe_accum_float: vector table of sums plus handshake, abort and reset sequences.
module tb_pe_accum_float;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_count;

    int compared = 0;
    int failed   = 0;

    typedef struct {
        int          n;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] exp_data;
        logic [7:0]  exp_count;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    exp_t mon_e;

    pe_accum_float #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one term and waits (bounded) for acceptance; gap = cycles spent waiting for in_ready.
    task automatic applyStimulus(input logic [31:0] d, input logic l, output int gap);
        gap      = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && gap < 40) begin
            tick();
            gap++;
        end
        if (!in_ready) begin
            compared++;
            failed++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            compared++;
            failed++;
            $display("[TB] FAIL result_timeout: out_valid stayed %b, expected 1", out_valid);
        end
    endtask

    function automatic logic [31:0] term_of(input vec_t v, input int i);
        case (i)
            0:       return v.t0;
            1:       return v.t1;
            default: return v.t2;
        endcase
    endfunction

    // Scoreboard consumer: each completed handshake must match the oldest expected sum.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL unexpected_output: got %h, expected no output", out_data);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sum_data", out_data, mon_e.d);
                checkOutput("sum_count", {24'd0, out_count}, {24'd0, mon_e.c});
            end
        end
    end

    initial begin
        int gap;
        int lat;
        int spurious;

        vecs[0]  = '{n: 1, t0: 32'h3F800000, t1: 32'h0,        t2: 32'h0,        exp_data: 32'h3F800000, exp_count: 8'd1};
        vecs[1]  = '{n: 2, t0: 32'h3F800000, t1: 32'h40000000, t2: 32'h0,        exp_data: 32'h40400000, exp_count: 8'd2};
        vecs[2]  = '{n: 2, t0: 32'h3F800000, t1: 32'hBF800000, t2: 32'h0,        exp_data: 32'h00000000, exp_count: 8'd2};
        vecs[3]  = '{n: 2, t0: 32'h3FC00000, t1: 32'hBF800000, t2: 32'h0,        exp_data: 32'h3F000000, exp_count: 8'd2};
        vecs[4]  = '{n: 2, t0: 32'h3F800000, t1: 32'h30800000, t2: 32'h0,        exp_data: 32'h3F800000, exp_count: 8'd2};
        vecs[5]  = '{n: 2, t0: 32'h00123456, t1: 32'h40000000, t2: 32'h0,        exp_data: 32'h40000000, exp_count: 8'd2};
        vecs[6]  = '{n: 2, t0: 32'h7F7FFFFF, t1: 32'h7F7FFFFF, t2: 32'h0,        exp_data: 32'h7F7FFFFF, exp_count: 8'd2};
        vecs[7]  = '{n: 2, t0: 32'h40000000, t1: 32'hBF800000, t2: 32'h0,        exp_data: 32'h3F800000, exp_count: 8'd2};
        vecs[8]  = '{n: 2, t0: 32'hC0400000, t1: 32'h3F800000, t2: 32'h0,        exp_data: 32'hC0000000, exp_count: 8'd2};
        vecs[9]  = '{n: 3, t0: 32'h3F800000, t1: 32'h3F800000, t2: 32'h3F800000, exp_data: 32'h40400000, exp_count: 8'd3};
        vecs[10] = '{n: 2, t0: 32'h00800000, t1: 32'h80C00000, t2: 32'h0,        exp_data: 32'h00000000, exp_count: 8'd2};
        vecs[11] = '{n: 2, t0: 32'h3F800001, t1: 32'h3F800000, t2: 32'h0,        exp_data: 32'h40000000, exp_count: 8'd2};

        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        repeat (2) tick();
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_out_count", {24'd0, out_count}, 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 12; v++) begin
            for (int t = 0; t < vecs[v].n; t++) begin
                if (t == vecs[v].n - 1) begin
                    sb.push_back('{d: vecs[v].exp_data, c: vecs[v].exp_count});
                end
                applyStimulus(term_of(vecs[v], t), (t == vecs[v].n - 1), gap);
                if (t > 0) begin
                    checkOutput("in_ready_gap", gap, 32'd3);
                end
            end
            waitResult(lat);
            checkOutput("latency", lat, 32'd3);
            tick();
        end

        // Consumer stalls in DONE for five cycles.
        out_ready = 1'b0;
        applyStimulus(32'h3F800000, 1'b0, gap);
        sb.push_back('{d: 32'h40400000, c: 8'd2});
        applyStimulus(32'h40000000, 1'b1, gap);
        waitResult(lat);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_data", out_data, 32'h40400000);
            checkOutput("hold_count", {24'd0, out_count}, 32'd2);
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("release_out_valid", {31'd0, out_valid}, 32'd0);

        sb.push_back('{d: 32'h40000000, c: 8'd1});
        applyStimulus(32'h40000000, 1'b1, gap);
        waitResult(lat);
        tick();

        // Abort while the term is in ADD; no result may appear.
        applyStimulus(32'h3F800000, 1'b1, gap);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("clr_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("clr_out_data", out_data, 32'h40000000);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) spurious++;
            tick();
        end
        checkOutput("clr_no_valid", spurious, 32'd0);
        sb.push_back('{d: 32'h3F800000, c: 8'd1});
        applyStimulus(32'h3F800000, 1'b1, gap);
        waitResult(lat);
        checkOutput("post_clr_latency", lat, 32'd3);
        tick();

        // Asynchronous reset with a term in flight.
        applyStimulus(32'h40000000, 1'b0, gap);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("async_rst_out_data", out_data, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        sb.push_back('{d: 32'h3F800000, c: 8'd1});
        applyStimulus(32'h3F800000, 1'b1, gap);
        waitResult(lat);
        tick();
        repeat (2) tick();

        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
